// File: rtl/acq_str.sv
// Stream acquire: gates an AXI4-stream sample flow into one framed acquisition
// (pre-trigger samples, trigger, post-trigger samples) with TLAST on the final sample.
module acq_str #(
  parameter int unsigned DN = 1,
  parameter int unsigned DW = 14,
  parameter int unsigned CW = 32
) (
  input  logic               clk,
  input  logic               rstn,
  // input stream
  input  logic [DN*DW-1:0]   sti_tdata,
  input  logic [DN-1:0]      sti_tkeep,
  input  logic               sti_tvalid,
  output logic               sti_tready,
  // framed output stream
  output logic [DN*DW-1:0]   sto_tdata,
  output logic [DN-1:0]      sto_tkeep,
  output logic               sto_tvalid,
  output logic               sto_tlast,
  input  logic               sto_tready,
  // control / status / events
  input  logic               ctl_rst,
  input  logic               ctl_str,
  output logic               sts_str,
  input  logic               ctl_stp,
  output logic               sts_stp,
  input  logic               ctl_trg,
  output logic               sts_trg,
  output logic               evn_lst,
  input  logic [CW-1:0]      cfg_pre,
  input  logic [CW-1:0]      cfg_pst,
  output logic [CW-1:0]      sts_pre,
  output logic [CW-1:0]      sts_pst,
  output logic               sts_acq
);

  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, PRE, ARM, PST} state_t;

  state_t        state;
  logic          xfer;
  logic          lst;
  logic          pre_done;
  logic [CW-1:0] pre_inc;

  // Zero-latency data path; samples are drained and dropped while idle.
  assign sti_tready = sts_acq ? sto_tready : 1'b1;
  assign xfer       = sti_tvalid & sti_tready;
  assign sto_tdata  = sti_tdata;
  assign sto_tkeep  = sti_tkeep;
  assign sto_tvalid = sti_tvalid & sts_acq;

  // Final post sample, suppressed when a higher-priority control ends the frame.
  assign lst       = (state == PST) && (sts_pst == cfg_pst) && !(ctl_rst || ctl_stp || ctl_str);
  assign sto_tlast = lst;

  assign pre_done = ({1'b0, sts_pre} + CW1'(xfer)) >= {1'b0, cfg_pre};
  assign pre_inc  = (sts_pre == CNT_MAX) ? sts_pre : sts_pre + CW'(1);

  always_ff @(posedge clk) begin
    sts_str <= 1'b0;
    sts_stp <= 1'b0;
    sts_trg <= 1'b0;
    evn_lst <= 1'b0;
    if (!rstn || ctl_rst) begin
      state   <= IDLE;
      sts_acq <= 1'b0;
      sts_pre <= '0;
      sts_pst <= '0;
    end else if (ctl_stp && sts_acq) begin
      // counters are left untouched for readout
      state   <= IDLE;
      sts_acq <= 1'b0;
      sts_stp <= 1'b1;
    end else if (ctl_str) begin
      state   <= (cfg_pre != '0) ? PRE : ARM;
      sts_acq <= 1'b1;
      sts_pre <= '0;
      sts_pst <= '0;
      sts_str <= 1'b1;
    end else begin
      case (state)
        PRE: begin
          if (xfer) sts_pre <= pre_inc;
          if (pre_done) state <= ARM;
        end
        ARM: begin
          if (xfer) sts_pre <= pre_inc;
          if (ctl_trg) begin
            state   <= PST;
            sts_pst <= '0;
            sts_trg <= 1'b1;
          end
        end
        PST: begin
          if (xfer) begin
            sts_pst <= sts_pst + CW'(1);
            if (lst) begin
              state   <= IDLE;
              sts_acq <= 1'b0;
              evn_lst <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_str.sv
// Bench for acq_str: table of framed acquisitions, randomized backpressure run
// against a frame-level model, and hand sequences for stop/reset/saturation.
module tb_acq_str;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] sti_tdata;
  logic        sti_tkeep;
  logic        sti_tvalid;
  logic        sti_tready;
  logic [13:0] sto_tdata;
  logic        sto_tkeep;
  logic        sto_tvalid;
  logic        sto_tlast;
  logic        sto_tready;
  logic        ctl_rst, ctl_str, ctl_stp, ctl_trg;
  logic        sts_str, sts_stp, sts_trg, evn_lst, sts_acq;
  logic [31:0] cfg_pre, cfg_pst, sts_pre, sts_pst;

  logic        sti_tready4;
  logic [13:0] sto_tdata4;
  logic        sto_tkeep4, sto_tvalid4, sto_tlast4;
  logic        sts_str4, sts_stp4, sts_trg4, evn_lst4, sts_acq4;
  logic [3:0]  sts_pre4, sts_pst4;

  always #5 clk = ~clk;

  acq_str #(.DN(1), .DW(14), .CW(32)) dut (
    .clk(clk), .rstn(rstn),
    .sti_tdata(sti_tdata), .sti_tkeep(sti_tkeep), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
    .sto_tdata(sto_tdata), .sto_tkeep(sto_tkeep), .sto_tvalid(sto_tvalid), .sto_tlast(sto_tlast),
    .sto_tready(sto_tready),
    .ctl_rst(ctl_rst), .ctl_str(ctl_str), .sts_str(sts_str), .ctl_stp(ctl_stp), .sts_stp(sts_stp),
    .ctl_trg(ctl_trg), .sts_trg(sts_trg), .evn_lst(evn_lst),
    .cfg_pre(cfg_pre), .cfg_pst(cfg_pst), .sts_pre(sts_pre), .sts_pst(sts_pst), .sts_acq(sts_acq)
  );

  // narrow-counter instance for the saturation case
  acq_str #(.DN(1), .DW(14), .CW(4)) dut4 (
    .clk(clk), .rstn(rstn),
    .sti_tdata(sti_tdata), .sti_tkeep(sti_tkeep), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready4),
    .sto_tdata(sto_tdata4), .sto_tkeep(sto_tkeep4), .sto_tvalid(sto_tvalid4), .sto_tlast(sto_tlast4),
    .sto_tready(sto_tready),
    .ctl_rst(ctl_rst), .ctl_str(ctl_str), .sts_str(sts_str4), .ctl_stp(ctl_stp), .sts_stp(sts_stp4),
    .ctl_trg(ctl_trg), .sts_trg(sts_trg4), .evn_lst(evn_lst4),
    .cfg_pre(cfg_pre[3:0]), .cfg_pst(cfg_pst[3:0]), .sts_pre(sts_pre4), .sts_pst(sts_pst4),
    .sts_acq(sts_acq4)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // output monitor: drained samples and pulse counts
  bit          mon_en = 1'b0;
  logic [13:0] q_data[$];
  bit          q_last[$];
  int          n_str, n_stp, n_trg, n_lst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (sto_tvalid && sto_tready) begin
        q_data.push_back(sto_tdata);
        q_last.push_back(sto_tlast);
      end
      if (sts_str) n_str++;
      if (sts_stp) n_stp++;
      if (sts_trg) n_trg++;
      if (evn_lst) n_lst++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_acq(input int pre, input int pst);
    sti_tvalid = 1'b0;
    ctl_trg = 1'b0; ctl_stp = 1'b0;
    ctl_rst = 1'b1;
    step();
    ctl_rst = 1'b0;
    q_data.delete(); q_last.delete();
    n_str = 0; n_stp = 0; n_trg = 0; n_lst = 0;
    cfg_pre = 32'(pre); cfg_pst = 32'(pst);
    mon_en = 1'b1;
    ctl_str = 1'b1;
    step();
    ctl_str = 1'b0;
  endtask

  // frame-level checks of whatever the monitor drained
  task automatic chk_frame(input string tag, input int len, input int lastpos, input int nlast);
    int errs, lp, nl;
    errs = 0; lp = -1; nl = 0;
    foreach (q_data[j]) begin
      if (q_data[j] != 14'(j)) errs++;
      if (q_last[j]) begin
        nl++;
        if (lp < 0) lp = j;
      end
    end
    chk({tag, "_len"}, q_data.size(), len);
    chk({tag, "_data_err"}, errs, 0);
    chk({tag, "_nlast"}, nl, nlast);
    chk({tag, "_lastpos"}, lp, lastpos);
  endtask

  typedef struct {
    int pre, pst;       // config
    int ta, tb, sp;     // sample index of trigger(s) / stop, -1 = none
    int len, lastpos, nlast;
    int exp_pre, exp_pst;
    int ntrg, nlst, nstp;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int k, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", k);
    sto_tready = 1'b1;
    start_acq(v.pre, v.pst);
    for (int i = 0; i < 64; i++) begin
      sti_tvalid = 1'b1;
      sti_tdata  = 14'(i);
      ctl_trg    = (i == v.ta) || (i == v.tb);
      ctl_stp    = (i == v.sp);
      step();
      if (!sts_acq) break;
    end
    sti_tvalid = 1'b0; ctl_trg = 1'b0; ctl_stp = 1'b0;
    step(); step();
    mon_en = 1'b0;
    chk_frame(tag, v.len, v.lastpos, v.nlast);
    chk({tag, "_sts_pre"}, sts_pre, v.exp_pre);
    chk({tag, "_sts_pst"}, sts_pst, v.exp_pst);
    chk({tag, "_n_str"}, n_str, 1);
    chk({tag, "_n_trg"}, n_trg, v.ntrg);
    chk({tag, "_n_lst"}, n_lst, v.nlst);
    chk({tag, "_n_stp"}, n_stp, v.nstp);
  endtask

  // Randomized backpressure run. Model: a trigger is honoured once cfg_pre samples
  // were accepted before its cycle; the frame is all accepted samples through the
  // trigger cycle plus cfg_pst+1 more.
  task automatic run_rand(input int pre, input int pst);
    int  m_acc, exp_pre, thr, cyc;
    bit  trg_done, x;
    m_acc = 0; exp_pre = 0; trg_done = 1'b0; cyc = 0;
    thr = pre + int'($urandom_range(0, 8));
    start_acq(pre, pst);
    sti_tdata = 14'(0);
    while (!(trg_done && m_acc >= exp_pre + pst + 1) && cyc < 3000) begin
      sti_tvalid = ($urandom_range(0, 9) < 7);
      sto_tready = ($urandom_range(0, 1) == 1);
      sti_tdata  = 14'(m_acc);
      ctl_trg    = !trg_done && (m_acc >= thr);
      x = sti_tvalid && sto_tready;
      step();
      if (ctl_trg) begin
        exp_pre  = m_acc + int'(x);
        trg_done = 1'b1;
      end
      if (x) m_acc++;
      cyc++;
    end
    sti_tvalid = 1'b0; ctl_trg = 1'b0; sto_tready = 1'b1;
    if (cyc >= 3000) chk("rnd_timeout", cyc, 0);
    step(); step();
    mon_en = 1'b0;
    chk_frame("rnd", exp_pre + pst + 1, exp_pre + pst, 1);
    chk("rnd_sts_pre", sts_pre, exp_pre);
    chk("rnd_sts_pst", sts_pst, pst + 1);
    chk("rnd_sts_acq", sts_acq, 0);
    chk("rnd_n_trg", n_trg, 1);
    chk("rnd_n_lst", n_lst, 1);
  endtask

  initial begin
    //          pre pst  ta  tb  sp  len last nl  pre pst trg lst stp
    vecs[0] = '{4,  2,   10, -1, -1, 14,  13, 1,  11, 3,  1,  1,  0};
    vecs[1] = '{4,  2,   2,  6,  -1, 10,  9,  1,  7,  3,  1,  1,  0};
    vecs[2] = '{0,  0,   0,  -1, -1, 2,   1,  1,  1,  1,  1,  1,  0};
    vecs[3] = '{4,  1,   3,  4,  -1, 7,   6,  1,  5,  2,  1,  1,  0};
    vecs[4] = '{4,  7,   10, -1, 12, 13,  -1, 0,  11, 1,  1,  0,  1};

    rstn = 1'b0;
    sti_tdata = '0; sti_tkeep = 1'b1; sti_tvalid = 1'b1; sto_tready = 1'b1;
    ctl_rst = 1'b0; ctl_str = 1'b0; ctl_stp = 1'b0; ctl_trg = 1'b0;
    cfg_pre = '0; cfg_pst = '0;
    repeat (3) step();
    rstn = 1'b1;
    step();
    chk("rst_sts_acq", sts_acq, 0);
    chk("rst_sts_pre", sts_pre, 0);
    chk("rst_sts_pst", sts_pst, 0);
    chk("rst_sto_tvalid", sto_tvalid, 0);
    chk("rst_sti_tready", sti_tready, 1);
    chk("rst_pulses", {sts_str, sts_stp, sts_trg, evn_lst}, 0);

    foreach (vecs[k]) run_vec(k, vecs[k]);

    // after vec 4 stop: counters held, stop while idle is inert, rst beats str
    chk("hold_sts_pre", sts_pre, 11);
    chk("hold_sts_pst", sts_pst, 1);
    ctl_stp = 1'b1;
    step();
    ctl_stp = 1'b0;
    chk("idle_stp_pulse", sts_stp, 0);
    ctl_rst = 1'b1; ctl_str = 1'b1;
    step();
    ctl_rst = 1'b0; ctl_str = 1'b0;
    chk("rststr_acq", sts_acq, 0);
    chk("rststr_pre", sts_pre, 0);
    chk("rststr_pst", sts_pst, 0);
    chk("rststr_str", sts_str, 0);

    // restart while armed clears counters
    start_acq(4, 2);
    sti_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sti_tdata = 14'(i);
      step();
    end
    chk("rearm_pre_before", sts_pre, 6);
    ctl_str = 1'b1;
    step();
    ctl_str = 1'b0; sti_tvalid = 1'b0;
    chk("rearm_str", sts_str, 1);
    chk("rearm_pre", sts_pre, 0);
    chk("rearm_acq", sts_acq, 1);
    mon_en = 1'b0;

    run_rand(16, 31);

    // narrow counter saturation, then trigger still honoured
    start_acq(15, 0);
    mon_en = 1'b0;
    sti_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sti_tdata = 14'(i);
      step();
    end
    chk("sat_pre", sts_pre4, 15);
    sti_tdata = 14'(20); ctl_trg = 1'b1;
    step();
    ctl_trg = 1'b0;
    chk("sat_trg", sts_trg4, 1);
    chk("sat_pre_trg", sts_pre4, 15);
    sti_tdata = 14'(21);
    #1;
    chk("sat_tlast", sto_tlast4, 1);
    step();
    sti_tvalid = 1'b0;
    chk("sat_evn_lst", evn_lst4, 1);
    chk("sat_acq", sts_acq4, 0);
    chk("sat_pst", sts_pst4, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
